// File: rtl/fetch_unit_pkg.sv
// Shared core constants: PC reset default and the control FSM stage codes.
package fetch_unit_pkg;

  // Address the core starts fetching from after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of the stage code driven by the control FSM.
  localparam int DEFAULT_STAGE_W = 5;

  // Stage codes of the multi-cycle control FSM.
  localparam logic [DEFAULT_STAGE_W-1:0] STAGE_FETCH     = 5'd0;
  localparam logic [DEFAULT_STAGE_W-1:0] STAGE_DECODE    = 5'd1;
  localparam logic [DEFAULT_STAGE_W-1:0] STAGE_EXECUTE   = 5'd2;
  localparam logic [DEFAULT_STAGE_W-1:0] STAGE_MEMORY    = 5'd3;
  localparam logic [DEFAULT_STAGE_W-1:0] STAGE_WRITEBACK = 5'd4;

endpackage

// File: rtl/fetch_unit.sv
// Program-counter holding stage of the multi-cycle RV32I core.
// The PC register loads the datapath's next-PC value verbatim when the
// control unit enables it; no alignment, increment or wrap logic lives here.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          STAGE_W  = DEFAULT_STAGE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCEn_reg,
  input  logic [31:0]        pc_up_reg,
  input  logic [STAGE_W-1:0] current_stage,
  output logic [31:0]        pc_reg
);

  // PC register: reset has priority over the write enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (PCEn_reg) begin
      pc_reg <= pc_up_reg;
    end
  end

`ifndef SYNTHESIS
  // Trace check: a PC load should only ever come from a defined stage code.
  always_ff @(posedge clk) begin
    if (!reset && PCEn_reg) begin
      assert (32'(current_stage) <= 32'(STAGE_WRITEBACK))
        else $error("fetch_unit: PC load in undefined stage %0d", current_stage);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process pushes the PC value
// expected after each edge, a separate monitor pops and compares it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        pcen;
  logic [31:0] pc_up;
  logic [4:0]  stage;
  logic [31:0] pc;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .PCEn_reg     (pcen),
    .pc_up_reg    (pc_up),
    .current_stage(stage),
    .pc_reg       (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;
  logic        stim_done = 1'b0;

  // Reference rule: reset wins, else an enabled edge copies the input, else hold.
  task automatic step(input logic r, input logic en, input logic [31:0] up,
                      input logic [4:0] st, input string name);
    exp_t e;
    @(negedge clk);
    reset = r;
    pcen  = en;
    pc_up = up;
    stage = st;
    if ($isunknown(en) && !r) begin
      errors++;
      $display("FAIL %s: PCEn_reg is X while reset=0 (got %b, required 0 or 1)", name, en);
    end
    if (r)       model_pc = DEFAULT_RESET_PC;
    else if (en) model_pc = up;
    e.name = name;
    e.exp  = model_pc;
    sb_q.push_back(e);
  endtask

  // Monitor: after every edge, compare pc_reg with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (pc !== e.exp) begin
          errors++;
          $display("FAIL %s: pc_reg=%h required %h", e.name, pc, e.exp);
        end else begin
          $display("check %s: pc_reg=%h ok", e.name, pc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    pcen  = 1'b0;
    pc_up = '0;
    stage = '0;

    // Directed sequence
    step(1'b1, 1'b0, 32'h0000_0000, STAGE_FETCH, "reset");
    step(1'b0, 1'b1, 32'h0000_2231, STAGE_FETCH, "load");
    step(1'b0, 1'b0, 32'h0000_5237, STAGE_FETCH, "hold1");
    step(1'b0, 1'b0, 32'h0000_5237, STAGE_FETCH, "hold2");
    step(1'b1, 1'b1, 32'hDEAD_BEEC, STAGE_EXECUTE, "priority");
    step(1'b0, 1'b1, 32'h0000_0004, STAGE_FETCH, "b2b_4");
    step(1'b0, 1'b1, 32'h0000_0008, STAGE_FETCH, "b2b_8");
    step(1'b0, 1'b1, 32'hFFFF_FFFC, STAGE_FETCH, "b2b_fffffffc");
    for (int s = 0; s < 5; s++)
      step(1'b0, 1'b0, 32'h1000_0000 + 32'(s), 5'(s), $sformatf("stage%0d_hold", s));
    for (int s = 0; s < 5; s++)
      step(1'b0, 1'b1, 32'h2000_0010 + 32'(s * 4), 5'(s), $sformatf("stage%0d_load", s));
    step(1'b1, 1'b0, 32'h0000_0000, STAGE_FETCH, "reset_mid");
    step(1'b0, 1'b1, 32'h0000_0101, STAGE_DECODE, "after_reset_load");

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $urandom(),
           5'($urandom_range(0, 4)), $sformatf("rand%0d", i));
    end

    // Let the monitor drain the last expectation.
    @(negedge clk);
    stim_done = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: stim_done=%b, required 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
